// File: rtl/capture_buffer.sv
// ============================================================================
// Module   : capture_buffer
// Purpose  : Sample-capture buffer with one-shot / circular recording and a
//            registered random-access read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_buffer #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [AW:0]      o_count,
    output logic [AW-1:0]    o_head,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] c_FULL      = (AW + 1)'(DEPTH);
    localparam logic [AW:0] c_FULL_LESS = (AW + 1)'(DEPTH - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_mode;
    logic             r_overflow;
    logic [AW:0]      r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_head;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_in_fill;
    logic w_arm;
    logic w_write;
    logic w_full;
    logic w_last_oneshot;
    logic w_end;

    assign w_in_fill      = (r_state == S_FILL);
    // start outranks stop whenever the buffer is not filling
    assign w_arm          = !w_in_fill && i_start;
    assign w_write        = w_in_fill && i_din_valid;
    assign w_full         = (r_count == c_FULL);
    assign w_last_oneshot = w_write && !r_mode && (r_count == c_FULL_LESS);
    assign w_end          = w_in_fill && (i_stop || w_last_oneshot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_head     <= '0;
            r_rd_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // read samples the array before this edge's write lands
            r_rd_data <= r_mem[i_rd_addr];

            if (w_arm) begin
                r_state    <= S_FILL;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_mode     <= i_mode;
                r_overflow <= 1'b0;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_head     <= '0;
            end else if (w_in_fill) begin
                if (w_write) begin
                    r_mem[r_wr_ptr] <= i_din;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    if (!w_full) begin
                        r_count <= r_count + 1'b1;
                    end else begin
                        // full circular buffer: oldest entry is overwritten
                        r_overflow <= 1'b1;
                        r_head     <= r_head + 1'b1;
                    end
                end
                if (w_end) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_count    = r_count;
    assign o_head     = r_head;
    assign o_rd_data  = r_rd_data;

endmodule

`default_nettype wire
